mem_bist_ctrl: RTL and testbench
================================

// Module: mem_bist_ctrl
// PURPOSE
//  Initiator that drives the addr/data_in/wr_enable/data_out port of a small parameterised
//  memory and checks its contents.
//  On start it runs a four-phase march: write pattern, read/compare, write inverse, read/compare.
//  Reports pass/fail plus the first failing address and data.
//  Sits between test/control logic and the memory, owning the memory port for the whole run.
// PARAMETERS
//  ADDR_WIDTH  3  width of mem_addr / fail_addr
//  DATA_WIDTH  4  width of memory data words
//  DEPTH       8  number of words tested, addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_WIDTH)
// PORTS
//  clk            in   1           rising-edge clock, single clock domain
//  rst_n          in   1           synchronous, active-low reset
//  start          in   1           request a test run; sampled only in IDLE
//  busy           out  1           high while a run is in progress (WR0/RD0/WR1/RD1)
//  done           out  1           one-cycle pulse when a run finishes
//  pass           out  1           1 = last run found no mismatch; valid from done until next accepted start
//  fail_addr      out  ADDR_WIDTH  address of first mismatch (0 if none)
//  fail_data      out  DATA_WIDTH  data read at first mismatch (0 if none)
//  mem_addr       out  ADDR_WIDTH  memory address
//  mem_data_in    out  DATA_WIDTH  memory write data
//  mem_wr_enable  out  1           memory write strobe
//  mem_data_out   in   DATA_WIDTH  memory read data; combinational from mem_addr (same-cycle)
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): state IDLE; every output 0; counter 0. Applies mid-run;
//    the run is abandoned with no done pulse.
//  - States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE -> IDLE.
//  - IDLE: start=1 at an edge -> WR0, addr counter 0, pass/fail_addr/fail_data cleared.
//  - start is ignored in every state except IDLE, including DONE.
//  - Pattern: P(a,inv) = a zero-extended or truncated to DATA_WIDTH, XOR {DATA_WIDTH{inv}}.
//    inv=0 for WR0/RD0, inv=1 for WR1/RD1.
//  - All mem_* outputs are registered and only change on clock edges.
//  - One address per cycle; the counter steps 0..DEPTH-1.
//  - At DEPTH-1 the state advances and the counter returns to 0; no wrap beyond DEPTH-1.
//  - WRx cycle: mem_addr=a, mem_data_in=P(a,inv), mem_wr_enable=1.
//  - RDx cycle: mem_addr=a, mem_wr_enable=0, mem_data_in=0. At the closing edge, compare
//    mem_data_out against P(a,inv).
//  - Mismatch: capture fail_addr=a, fail_data=mem_data_out; go directly to DONE with pass=0.
//    Later addresses and phases are skipped.
//  - RD1 completes with no mismatch -> DONE with pass=1.
//  - DONE: lasts one cycle; done=1, busy=0, mem_wr_enable=0; then IDLE.
//    pass/fail_* hold until the next accepted start.
//  - busy=1 exactly in WR0/RD0/WR1/RD1.
//  - Timing: start accepted at edge E0 -> busy for 4*DEPTH cycles.
//    done is high in the cycle after edge E(4*DEPTH) (fault-free run).
// TESTING
//  1. Fault-free memory model, DEPTH=8, 1-cycle start pulse -> busy 32 cycles;
//     writes 0..7 with 4'h0..4'h7, then 4'hF..4'h8; done 1 cycle; pass=1, fail_addr=0, fail_data=0.
//  2. Model addr 6 bit3 stuck-at-1 -> mismatch in RD0 (expect 4'h6, read 4'hE);
//     done after edge 15; pass=0, fail_addr=6, fail_data=4'hE; WR1 never entered.
//  3. Model addr 3 bit0 stuck-at-1 -> RD0 passes; RD1 expects 4'hC, reads 4'hD;
//     done after edge 28; pass=0, fail_addr=3, fail_data=4'hD.
//  4. start held high continuously -> runs back-to-back with exactly one DONE and one IDLE cycle
//     between them; pass cleared at the second accept.
//  5. rst_n=0 for one edge at cycle 10 of a run -> next cycle all outputs 0, IDLE, no done;
//     a new start then gives a full 32-cycle run with pass=1.
//  6. DEPTH=6 instance -> only addresses 0..5 driven; busy 24 cycles; pass=1.

Source files
------------

// File: rtl/mem_bist_if.sv
// Memory-side port bundle of the BIST controller.
// The BIST engine is the master: it drives the address, write data and write strobe.
// The memory is the slave: it returns read data combinationally from the address.
interface mem_bist_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_wr_enable;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport master (
    output mem_addr,
    output mem_data_in,
    output mem_wr_enable,
    input  mem_data_out
  );

  modport slave (
    input  mem_addr,
    input  mem_data_in,
    input  mem_wr_enable,
    output mem_data_out
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Four-phase march BIST controller.
// A run writes an address-derived pattern, reads it back, writes the inverted pattern,
// and reads that back. It stops at the first mismatch and records its address and data.
// The memory port is fully registered, so each address gets exactly one cycle.
module mem_bist_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  mem_bist_if.master            bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    WR1,
    RD1,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] next_cnt;
  logic                  inv;

  // Address-derived test word: zero-extend or truncate the address, then optionally invert.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic inv_sel);
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    return ext[DATA_WIDTH-1:0] ^ {DATA_WIDTH{inv_sel}};
  endfunction

  assign next_cnt = cnt + 1'b1;
  assign inv      = (state == WR1) || (state == RD1);

  // March sequencer; every output, including the memory port, is a register set here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      fail_addr         <= '0;
      fail_data         <= '0;
      bus.mem_addr      <= '0;
      bus.mem_data_in   <= '0;
      bus.mem_wr_enable <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state             <= WR0;
            cnt               <= '0;
            busy              <= 1'b1;
            pass              <= 1'b0;
            fail_addr         <= '0;
            fail_data         <= '0;
            bus.mem_addr      <= '0;
            bus.mem_data_in   <= pattern('0, 1'b0);
            bus.mem_wr_enable <= 1'b1;
          end
        end

        WR0, WR1: begin
          if (cnt == LAST) begin
            state             <= (state == WR0) ? RD0 : RD1;
            cnt               <= '0;
            bus.mem_addr      <= '0;
            bus.mem_data_in   <= '0;
            bus.mem_wr_enable <= 1'b0;
          end else begin
            cnt             <= next_cnt;
            bus.mem_addr    <= next_cnt;
            bus.mem_data_in <= pattern(next_cnt, inv);
          end
        end

        RD0, RD1: begin
          if (bus.mem_data_out != pattern(cnt, inv)) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
            fail_addr    <= cnt;
            fail_data    <= bus.mem_data_out;
            cnt          <= '0;
            bus.mem_addr <= '0;
          end else if (cnt == LAST) begin
            cnt          <= '0;
            bus.mem_addr <= '0;
            if (state == RD0) begin
              state             <= WR1;
              bus.mem_data_in   <= pattern('0, 1'b1);
              bus.mem_wr_enable <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else begin
            cnt          <= next_cnt;
            bus.mem_addr <= next_cnt;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl.
// Two instances (DEPTH 8 and DEPTH 6) each drive a behavioural memory; the DEPTH 8 memory
// can have one stuck bit planted. Each run is compared against an outcome computed by
// walking the march phases directly over addresses.
module tb_mem_bist_ctrl;

  localparam int AW = 3;
  localparam int DW = 4;
  localparam int DA = 8;
  localparam int DB = 6;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  always #5 clk = ~clk;

  mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  logic          busy_a, done_a, pass_a;
  logic [AW-1:0] fail_addr_a;
  logic [DW-1:0] fail_data_a;
  logic          busy_b, done_b, pass_b;
  logic [AW-1:0] fail_addr_b;
  logic [DW-1:0] fail_data_b;

  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DA)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .fail_addr (fail_addr_a),
    .fail_data (fail_data_a),
    .bus       (bus_a.master)
  );

  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DB)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .fail_addr (fail_addr_b),
    .fail_data (fail_data_b),
    .bus       (bus_b.master)
  );

  logic [DW-1:0] mem_a [0:7];
  logic [DW-1:0] mem_b [0:7];

  logic fault_en  = 1'b0;
  int   fault_addr = 0;
  int   fault_bit  = 0;
  logic fault_val  = 1'b0;

  // Synchronous memory writes for both instances.
  always @(posedge clk) begin
    if (bus_a.mem_wr_enable) mem_a[bus_a.mem_addr] <= bus_a.mem_data_in;
    if (bus_b.mem_wr_enable) mem_b[bus_b.mem_addr] <= bus_b.mem_data_in;
  end

  // Combinational read of memory A with an optional stuck-at bit.
  always_comb begin : rd_a
    logic [DW-1:0] v;
    v = mem_a[bus_a.mem_addr];
    if (fault_en && (int'(bus_a.mem_addr) == fault_addr)) v[fault_bit] = fault_val;
    bus_a.mem_data_out = v;
  end

  assign bus_b.mem_data_out = mem_b[bus_b.mem_addr];

  int            sel = 0;
  logic          obs_busy, obs_done, obs_pass, obs_wr;
  logic [AW-1:0] obs_fa, obs_addr;
  logic [DW-1:0] obs_fd, obs_din;

  // Observation mux so one run task can watch either instance.
  always_comb begin
    if (sel != 0) begin
      obs_busy = busy_b; obs_done = done_b; obs_pass = pass_b;
      obs_fa = fail_addr_b; obs_fd = fail_data_b;
      obs_addr = bus_b.mem_addr; obs_din = bus_b.mem_data_in; obs_wr = bus_b.mem_wr_enable;
    end else begin
      obs_busy = busy_a; obs_done = done_a; obs_pass = pass_a;
      obs_fa = fail_addr_a; obs_fd = fail_data_a;
      obs_addr = bus_a.mem_addr; obs_din = bus_a.mem_data_in; obs_wr = bus_a.mem_wr_enable;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  int exp_wr[$];
  int obs_wr_q[$];
  int exp_pass, exp_k, exp_fa, exp_fd;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int pat(input int a, input bit inv);
    return (a % (1 << DW)) ^ (inv ? ((1 << DW) - 1) : 0);
  endfunction

  function automatic int readback(input int a, input int v);
    if (fault_en && a == fault_addr)
      return fault_val ? (v | (1 << fault_bit)) : (v & ~(1 << fault_bit));
    return v;
  endfunction

  // Walk write/read phases address by address and stop at the first bad read.
  task automatic buildModel(input int depth, input bit use_fault);
    int rd;
    exp_wr.delete();
    exp_pass = 1; exp_k = 4 * depth; exp_fa = 0; exp_fd = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < depth; a++) exp_wr.push_back(a * 16 + pat(a, ph[0]));
      for (int a = 0; a < depth; a++) begin
        rd = use_fault ? readback(a, pat(a, ph[0])) : pat(a, ph[0]);
        if (rd != pat(a, ph[0])) begin
          exp_pass = 0; exp_fa = a; exp_fd = rd;
          exp_k = (2 * ph + 1) * depth + a + 1;
          return;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int s, input int gap);
    int depth, done_k, busy_cnt, bad_addr, bad_data;
    bit seen, busy_at_done;
    sel = s;
    depth = (s != 0) ? DB : DA;
    buildModel(depth, (s == 0));
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if (s != 0) start_b = 1'b1; else start_a = 1'b1;
    obs_wr_q.delete();
    seen = 0; done_k = -1; busy_cnt = 0; bad_addr = 0; bad_data = 0; busy_at_done = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (obs_wr) obs_wr_q.push_back(int'(obs_addr) * 16 + int'(obs_din));
      if (!obs_wr && obs_din != '0) bad_data++;
      if (obs_busy && int'(obs_addr) >= depth) bad_addr++;
      if (obs_done) begin
        seen = 1; done_k = k; busy_at_done = obs_busy;
        break;
      end
      if (obs_busy) busy_cnt++;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("done_cycle", 32'(done_k), 32'(exp_k));
    checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_k));
    checkOutput("busy_at_done", 32'(busy_at_done), 32'd0);
    checkOutput("pass", 32'(obs_pass), 32'(exp_pass));
    checkOutput("fail_addr", 32'(obs_fa), 32'(exp_fa));
    checkOutput("fail_data", 32'(obs_fd), 32'(exp_fd));
    checkOutput("write_count", 32'(obs_wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr_q.size(); i++)
      checkOutput("write_addr_data", 32'(obs_wr_q[i]), 32'(exp_wr[i]));
    checkOutput("addr_range", 32'(bad_addr), 32'd0);
    checkOutput("idle_data_zero", 32'(bad_data), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(obs_done), 32'd0);
    checkOutput("pass_hold", 32'(obs_pass), 32'(exp_pass));
  endtask

  initial begin
    int cnt;
    bit seen;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_pass", 32'(pass_a), 32'd0);
    checkOutput("rst_wr", 32'(bus_a.mem_wr_enable), 32'd0);
    checkOutput("rst_addr", 32'(bus_a.mem_addr), 32'd0);
    rst_n = 1'b1;

    $display("[TB] fault-free run, DEPTH 8");
    fault_en = 1'b0;
    applyStimulus(0, 0);

    $display("[TB] addr 6 bit 3 stuck at 1");
    fault_en = 1'b1; fault_addr = 6; fault_bit = 3; fault_val = 1'b1;
    applyStimulus(0, 1);

    $display("[TB] addr 3 bit 0 stuck at 1");
    fault_addr = 3; fault_bit = 0; fault_val = 1'b1;
    applyStimulus(0, 2);

    $display("[TB] randomized faults");
    for (int r = 0; r < 12; r++) begin
      fault_en   = ($urandom_range(0, 3) != 0);
      fault_addr = int'($urandom_range(0, 7));
      fault_bit  = int'($urandom_range(0, DW - 1));
      fault_val  = 1'($urandom_range(0, 1));
      applyStimulus(0, int'($urandom_range(0, 3)));
    end

    $display("[TB] start held high");
    fault_en = 1'b0; sel = 0;
    @(negedge clk);
    start_a = 1'b1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    checkOutput("held_first_done", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("held_idle_busy", 32'(busy_a), 32'd0);
    checkOutput("held_idle_done", 32'(done_a), 32'd0);
    checkOutput("held_idle_pass", 32'(pass_a), 32'd1);
    @(negedge clk);
    checkOutput("held_restart_busy", 32'(busy_a), 32'd1);
    checkOutput("held_restart_pass", 32'(pass_a), 32'd0);
    start_a = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    checkOutput("held_second_done", 32'(seen), 32'd1);
    checkOutput("held_second_pass", 32'(pass_a), 32'd1);
    @(negedge clk);

    $display("[TB] reset mid-run");
    start_a = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy_a), 32'd0);
    checkOutput("midrst_done", 32'(done_a), 32'd0);
    checkOutput("midrst_pass", 32'(pass_a), 32'd0);
    checkOutput("midrst_fail_addr", 32'(fail_addr_a), 32'd0);
    checkOutput("midrst_fail_data", 32'(fail_data_a), 32'd0);
    checkOutput("midrst_addr", 32'(bus_a.mem_addr), 32'd0);
    checkOutput("midrst_din", 32'(bus_a.mem_data_in), 32'd0);
    checkOutput("midrst_wr", 32'(bus_a.mem_wr_enable), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a || busy_a) cnt++;
    end
    checkOutput("midrst_quiet", 32'(cnt), 32'd0);
    applyStimulus(0, 0);

    $display("[TB] DEPTH 6 instance");
    applyStimulus(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
